// File: rtl/mycpu_pkg.sv
// Shared definitions for the CPU pipeline: bus widths, ALU/divider opcodes,
// divider FSM states, the decode->execute bus layout and a magnitude helper.
package mycpu_pkg;

  // The divider is radix-2 on 32-bit operands: one quotient bit per step.
  localparam int unsigned DIV_CYCLES      = 32;
  localparam int unsigned DS_TO_ES_BUS_WD = 143;
  localparam int unsigned ES_TO_MS_BUS_WD = 71;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluSlt  = 4'd2,
    AluSltu = 4'd3,
    AluAnd  = 4'd4,
    AluOr   = 4'd5,
    AluNor  = 4'd6,
    AluXor  = 4'd7,
    AluSll  = 4'd8,
    AluSrl  = 4'd9,
    AluSra  = 4'd10,
    AluLui  = 4'd11
  } alu_op_t;

  typedef enum logic [1:0] {
    DivNone = 2'b00,
    DivQuo  = 2'b01,
    DivRem  = 2'b10
  } div_op_t;

  typedef enum logic [1:0] {
    DivIdle,
    DivBusy,
    DivDone
  } div_state_t;

  // Field order matches the packed decode->execute bus, MSB first.
  typedef struct packed {
    div_op_t     div_op;
    logic        div_signed;
    alu_op_t     alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] rkd_value;
    logic        mem_we;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] pc;
  } ds_to_es_bus_t;

  // Magnitude of v when treated as signed, otherwise v unchanged.
  function automatic logic [31:0] abs_if(input logic sgn, input logic [31:0] v);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/exe_stage_if.sv
// Execute-stage interface bundle: decode handshake/bus, mem_stage handshake/bus,
// EX->ID forwarding/hazard signals and the data SRAM request.
//   slave  : execute-stage view (consumes the decode bus, drives everything else)
//   master : surrounding pipeline view (decode, mem_stage, data SRAM)
interface exe_stage_if;

  logic                                  ms_allowin;
  logic                                  es_allowin;
  logic                                  ds_to_es_valid;
  logic [mycpu_pkg::DS_TO_ES_BUS_WD-1:0] ds_to_es_bus;
  logic                                  es_to_ms_valid;
  logic [mycpu_pkg::ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic [4:0]                            es_to_ds_dest;
  logic                                  es_forward_valid;
  logic [4:0]                            es_forward_addr;
  logic [31:0]                           es_forward_data;
  logic                                  es_fwd_block;
  logic                                  data_sram_en;
  logic [3:0]                            data_sram_we;
  logic [31:0]                           data_sram_addr;
  logic [31:0]                           data_sram_wdata;

  modport slave (
    input  ms_allowin, ds_to_es_valid, ds_to_es_bus,
    output es_allowin, es_to_ms_valid, es_to_ms_bus, es_to_ds_dest,
           es_forward_valid, es_forward_addr, es_forward_data, es_fwd_block,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );

  modport master (
    output ms_allowin, ds_to_es_valid, ds_to_es_bus,
    input  es_allowin, es_to_ms_valid, es_to_ms_bus, es_to_ds_dest,
           es_forward_valid, es_forward_addr, es_forward_data, es_fwd_block,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );

endinterface

// File: rtl/exe_divider.sv
// Iterative radix-2 restoring divider, signed or unsigned, 32-bit.
//   clk, resetn          : clock, async active-low reset
//   start                : begin a division (sampled in Idle only)
//   signed_op            : treat operands as two's complement
//   dividend, divisor    : operands, sampled on start
//   ack                  : result consumed, return to Idle
//   busy, done           : FSM in Busy / Done
//   quotient, remainder  : sign-corrected results, valid while done
module exe_divider
  import mycpu_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam logic [4:0] LastStep = 5'(DIV_CYCLES - 1);

  div_state_t  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;   // shifts dividend bits out, quotient bits in
  logic [31:0] dvs_q, dvs_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;

  logic [32:0] trial;
  logic        ge;
  logic [31:0] sub;

  assign trial = {rem_q, quo_q[31]};
  assign ge    = trial >= {1'b0, dvs_q};
  // When ge holds the true difference is below the divisor, so the low 32 bits suffice.
  assign sub   = trial[31:0] - dvs_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    unique case (state_q)
      DivIdle: begin
        if (start) begin
          state_d = DivBusy;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = abs_if(signed_op, dividend);
          dvs_d   = abs_if(signed_op, divisor);
          q_neg_d = signed_op && (dividend[31] ^ divisor[31]);
          r_neg_d = signed_op && dividend[31];
        end
      end
      DivBusy: begin
        rem_d = ge ? sub : trial[31:0];
        quo_d = {quo_q[30:0], ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LastStep) begin
          state_d = DivDone;
        end
      end
      DivDone: begin
        if (ack) begin
          state_d = DivIdle;
        end
      end
      default: state_d = DivIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= DivIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end

  assign busy      = (state_q == DivBusy);
  assign done      = (state_q == DivDone);
  assign quotient  = q_neg_q ? (32'd0 - quo_q) : quo_q;
  assign remainder = r_neg_q ? (32'd0 - rem_q) : rem_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, iterative div/mod, data SRAM request, EX->MS bus packing
// and EX->ID forwarding/hazard indication.
//   clk, resetn : clock, async active-low reset
//   exe_if      : pipeline bundle (decode in, mem_stage out, forwarding, data SRAM)
module exe_stage
  import mycpu_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  exe_stage_if.slave  exe_if
);

  ds_to_es_bus_t ds_q;
  logic          es_valid_q, es_valid_d;
  logic          es_ready_go;
  logic          es_allowin;
  logic          es_to_ms_valid;
  logic          is_div;

  logic          div_start, div_busy, div_done;
  logic [31:0]   div_quo, div_rem;

  logic [31:0]   add_res;
  logic [31:0]   alu_res;
  logic [31:0]   es_result;

  assign is_div         = (ds_q.div_op != DivNone);
  assign es_ready_go    = !is_div || div_done;
  assign es_to_ms_valid = es_valid_q && es_ready_go;
  assign es_allowin     = !es_valid_q || (es_ready_go && exe_if.ms_allowin);
  assign es_valid_d     = es_allowin ? exe_if.ds_to_es_valid : es_valid_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      es_valid_q <= 1'b0;
    end else begin
      es_valid_q <= es_valid_d;
    end
  end

  // Payload is qualified by es_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (exe_if.ds_to_es_valid && es_allowin) begin
      ds_q <= ds_to_es_bus_t'(exe_if.ds_to_es_bus);
    end
  end

  // ALU
  assign add_res = ds_q.src1 + ds_q.src2;

  always_comb begin
    alu_res = '0;
    case (ds_q.alu_op)
      AluAdd:  alu_res = add_res;
      AluSub:  alu_res = ds_q.src1 - ds_q.src2;
      AluSlt:  alu_res = {31'd0, $signed(ds_q.src1) < $signed(ds_q.src2)};
      AluSltu: alu_res = {31'd0, ds_q.src1 < ds_q.src2};
      AluAnd:  alu_res = ds_q.src1 & ds_q.src2;
      AluOr:   alu_res = ds_q.src1 | ds_q.src2;
      AluNor:  alu_res = ~(ds_q.src1 | ds_q.src2);
      AluXor:  alu_res = ds_q.src1 ^ ds_q.src2;
      AluSll:  alu_res = ds_q.src1 << ds_q.src2[4:0];
      AluSrl:  alu_res = ds_q.src1 >> ds_q.src2[4:0];
      AluSra:  alu_res = $signed(ds_q.src1) >>> ds_q.src2[4:0];
      AluLui:  alu_res = ds_q.src2;
      default: alu_res = '0;
    endcase
  end

  // Divider only accepts a start while idle; busy/done mean the current
  // instruction already owns it.
  assign div_start = es_valid_q && is_div && !div_busy && !div_done;

  exe_divider u_divider (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start),
    .signed_op (ds_q.div_signed),
    .dividend  (ds_q.src1),
    .divisor   (ds_q.src2),
    .ack       (es_to_ms_valid && exe_if.ms_allowin),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    es_result = alu_res;
    if (ds_q.div_op == DivQuo) begin
      es_result = div_quo;
    end else if (ds_q.div_op == DivRem) begin
      es_result = div_rem;
    end
  end

  assign exe_if.es_allowin     = es_allowin;
  assign exe_if.es_to_ms_valid = es_to_ms_valid;
  assign exe_if.es_to_ms_bus   = {ds_q.res_from_mem, ds_q.gr_we, ds_q.dest, es_result, ds_q.pc};
  assign exe_if.es_to_ds_dest  = es_valid_q ? ds_q.dest : 5'd0;

  // Forwarding
  assign exe_if.es_forward_valid = es_valid_q && ds_q.gr_we && !ds_q.res_from_mem && es_ready_go;
  assign exe_if.es_forward_addr  = es_valid_q ? ds_q.dest : 5'd0;
  assign exe_if.es_forward_data  = es_valid_q ? es_result : 32'd0;
  assign exe_if.es_fwd_block     = es_valid_q && ds_q.gr_we && (ds_q.res_from_mem || !es_ready_go);

  // Data SRAM request: issued only on the cycle mem_stage can take it.
  assign exe_if.data_sram_en    = es_valid_q && (ds_q.mem_we || ds_q.res_from_mem)
                                  && exe_if.ms_allowin;
  assign exe_if.data_sram_we    = {4{es_valid_q && ds_q.mem_we && exe_if.ms_allowin}};
  assign exe_if.data_sram_addr  = es_valid_q ? add_res : 32'd0;
  assign exe_if.data_sram_wdata = es_valid_q ? ds_q.rkd_value : 32'd0;

endmodule
